// File: rtl/ysyx_25040111_lsu.sv
// Load/store unit: one request at a time from execute, single-outstanding
// memory bus with byte-lane alignment, load writeback via a reg_ready strobe.
module ysyx_25040111_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] raddr,
  input  logic [4:0]  wbaddr,
  input  logic [1:0]  rmask,
  input  logic        rsign,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [1:0]  wmask,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        reg_ready,
  output logic [4:0]  ardo,
  output logic [31:0] rdo,
  output logic        st_done,
  output logic        lsu_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_WB} state_t;

  // Counter only has to reach TIMEOUT-1, since the expiry check fires in the
  // RESP cycle where one more increment would hit TIMEOUT.
  localparam int unsigned   CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          st_q, sign_q;
  logic [31:0]   addr_q, wdata_q;
  logic [1:0]    size_q;
  logic [4:0]    wb_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rdo_q;
  logic [4:0]    ardo_q;
  logic          err_q, done_q;

  logic          acc_w, acc_r, accept, req_mis;
  logic [31:0]   req_addr;
  logic [1:0]    req_size;
  logic          err_set, done_set, ld_cap;
  logic [4:0]    lane_sh;

  function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] sz);
    if (sz == 2'b01)  return lo[0];
    else if (sz[1])   return (lo != 2'b00);
    else              return 1'b0;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                         input logic sg);
    case (sz)
      2'b00:   return {{24{sg & w[7]}}, w[7:0]};
      2'b01:   return {{16{sg & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign lane_sh = {addr_q[1:0], 3'b000};

  // Execute-side handshake, request selection and bus/writeback drive
  always_comb begin
    wready    = (state_q == S_IDLE) && reset;
    rready    = wready && !wvalid;
    acc_w     = wvalid && wready;
    acc_r     = rvalid && rready;
    accept    = acc_w || acc_r;
    req_addr  = acc_w ? waddr : raddr;
    req_size  = acc_w ? wmask : rmask;
    req_mis   = misaligned(req_addr[1:0], req_size);
    mem_valid = (state_q == S_REQ);
    mem_wen   = mem_valid && st_q;
    mem_addr  = mem_valid ? {addr_q[31:2], 2'b00} : '0;
    mem_wdata = mem_wen ? (wdata_q << lane_sh) : '0;
    mem_wstrb = '0;
    if (mem_wen) begin
      case (size_q)
        2'b00:   mem_wstrb = 4'b0001 << addr_q[1:0];
        2'b01:   mem_wstrb = 4'b0011 << addr_q[1:0];
        default: mem_wstrb = 4'b1111;
      endcase
    end
    reg_ready = (state_q == S_WB) && (wb_q != 5'd0);
    busy      = (state_q != S_IDLE);
  end

  // Next-state logic and one-cycle event decode
  always_comb begin
    state_d  = state_q;
    err_set  = 1'b0;
    done_set = 1'b0;
    ld_cap   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_mis) err_set = 1'b1;
          else         state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_rvalid) begin
          if (mem_err) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end else if (st_q) begin
            done_set = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ld_cap  = 1'b1;
            state_d = S_WB;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request latch, response counter, writeback and pulse registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q    <= 1'b0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
      rdo_q   <= '0;
      ardo_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (accept) begin
        st_q   <= acc_w;
        addr_q <= req_addr;
        size_q <= req_size;
        if (acc_w) begin
          wdata_q <= wdata;
        end else begin
          sign_q <= rsign;
          wb_q   <= wbaddr;
        end
      end
      if (state_q == S_RESP)                cnt_q <= cnt_q + 1'b1;
      else if (mem_valid && mem_ready)      cnt_q <= '0;
      if (ld_cap) begin
        rdo_q  <= extend(mem_rdata >> lane_sh, size_q, sign_q);
        ardo_q <= wb_q;
      end
      err_q  <= err_set;
      done_q <= done_set;
    end
  end

  assign rdo     = rdo_q;
  assign ardo    = ardo_q;
  assign lsu_err = err_q;
  assign st_done = done_q;

endmodule

// File: doc/ysyx_25040111_lsu.md
Name: ysyx_25040111_lsu

Overview:
Load/store unit directly downstream of the execute stage. Accepts one load or store request per transaction over the execute stage's valid/ready channels. It issues the request on a single-outstanding memory bus with byte-lane alignment. Load data is extracted and sign- or zero-extended, then written back to the register file by a one-cycle reg_ready pulse.

Parameters:
TIMEOUT, 255, max cycles waiting for mem_rvalid after mem handshake; 0 disables timeout

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
rvalid  in  1  load request valid from execute
rready  out  1  load request accepted
raddr  in  32  load byte address
wbaddr  in  5  destination register of load
rmask  in  2  load size: 00 byte, 01 half, 10/11 word
rsign  in  1  1 = sign-extend, 0 = zero-extend
wvalid  in  1  store request valid from execute
wready  out  1  store request accepted
waddr  in  32  store byte address
wdata  in  32  store data, right-aligned
wmask  in  2  store size, same encoding as rmask
mem_valid  out  1  bus request valid
mem_ready  in  1  bus request accepted
mem_wen  out  1  1 = write
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  32  lane-shifted store data
mem_wstrb  out  4  byte strobes, 0 for reads
mem_rvalid  in  1  bus response valid (read data or write ack)
mem_rdata  in  32  read word
mem_err  in  1  response error, qualified by mem_rvalid
reg_ready  out  1  one-cycle register writeback strobe
ardo  out  5  writeback register index
rdo  out  32  writeback data
st_done  out  1  one-cycle store-complete pulse
lsu_err  out  1  one-cycle error pulse (misalign, bus error, timeout)
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, REQ, RESP, WB.
- Reset (async, reset=0): state=IDLE, timeout counter=0, all latched fields=0. All outputs 0 except rready=wready=1 once reset deasserts. Reset mid-transaction aborts silently; no pulse is emitted.
- wready = (state==IDLE). rready = (state==IDLE) & ~wvalid. When both valids are high, the store wins and the load is held.
- On accept, latch the address, size, sign, wbaddr and data.
- Accepting a misaligned request (half with addr[0]=1; word with addr[1:0]!=0) makes no bus request. lsu_err pulses the next cycle and state stays IDLE.
- Otherwise the FSM goes to REQ.
- REQ: mem_valid=1, with fields driven from the latched registers and held stable until mem_ready. On mem_valid&mem_ready go to RESP and clear the counter.
- Store lanes: off=addr[1:0]; mem_wdata = wdata << (8*off). wstrb = 0001<<off (byte), 0011<<off (half), 1111 (word).
- RESP: the counter increments each cycle. On mem_rvalid:
  - mem_err=1: lsu_err pulse, go to IDLE, no writeback and no st_done.
  - store: st_done pulse, go to IDLE.
  - load: capture rdata>>(8*off) into the data register, go to WB.
- If TIMEOUT!=0 and the counter reaches TIMEOUT without mem_rvalid: lsu_err pulse, go to IDLE. Any later stray mem_rvalid in IDLE is ignored.
- WB: reg_ready=1 for exactly one cycle. ardo=latched wbaddr. rdo = the extracted byte/half/word with bits above the size filled by rsign ? msb : 0. Then go to IDLE.
- reg_ready is suppressed when wbaddr==0; the cycle still passes through WB.
- Latency with a zero-wait bus: accept at cycle 0, mem_valid at 1, response at 2 (earliest), reg_ready at 3. The next request is accepted at 3 for a store or 4 for a load (WB→IDLE).
- ardo/rdo hold their last value outside WB. st_done, lsu_err and reg_ready are never asserted simultaneously.

Test Plan:
- LB, raddr=0x80000003, rsign=1, mem_rdata=0x80FF1234 → mem_addr=0x80000000, wstrb=0, reg_ready pulse with rdo=0xFFFFFF80.
- LHU, raddr=0x80000002, rsign=0, mem_rdata=0xBEEF0000 → rdo=0x0000BEEF; LW at offset 0 returns mem_rdata unchanged.
- SB, waddr=0x10000001, wdata=0x000000AB → mem_wdata=0x0000AB00, wstrb=0010, st_done one cycle after mem_rvalid; no reg_ready.
- rvalid and wvalid high together → store accepted first (rready=0), load accepted on return to IDLE; mem_ready held low 5 cycles → mem_valid and fields stable throughout.
- Misaligned LW at 0x...2 → no mem_valid, lsu_err one pulse. mem_err on a load → lsu_err, no reg_ready. TIMEOUT=4 with no response → lsu_err after 4 RESP cycles.
- reset driven low during RESP → all outputs 0 immediately, IDLE after release, and no pulses from the aborted request.
